// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM slave.
package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    ACK_DEV,
    WORD_ADDR,
    ACK_WORD,
    WRITE,
    ACK_WRITE,
    READ,
    MACK,
    IGNORE
  } state_t;

  localparam logic READ_BIT  = 1'b1;
  localparam logic WRITE_BIT = 1'b0;

  localparam logic [6:0] DEF_ADDRESS    = 7'b1010_000;
  localparam int         DEF_MEM_BYTES  = 256;
  localparam int         DEF_PAGE_BYTES = 16;

endpackage

// File: rtl/i2c_eeprom_if.sv
// Board-side I2C pad signals seen by the EEPROM slave.
// sda_i is the resolved open-drain line, so it already reflects sda_oe_o.
interface i2c_eeprom_if;
  import i2c_eeprom_pkg::*;

  logic scl_i;
  logic sda_i;
  logic sda_oe_o;
  logic busy_o;

  modport slave  (input  scl_i, sda_i, output sda_oe_o, busy_o);
  modport master (output scl_i, sda_i, input  sda_oe_o, busy_o);
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus a history stage that yields
// SCL edges and START/STOP conditions.
module i2c_line_sync
  import i2c_eeprom_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0] line_in;
  logic [1:0] line_now;
  logic [1:0] line_prev;

  assign line_in = {sda_i, scl_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic meta_reg;
    logic sync_reg;
    logic hist_reg;

    // Synchronize one line and keep its previous sample; idle bus is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
        hist_reg <= 1'b1;
      end else begin
        meta_reg <= line_in[gi];
        sync_reg <= meta_reg;
        hist_reg <= sync_reg;
      end
    end

    assign line_now[gi]  = sync_reg;
    assign line_prev[gi] = hist_reg;
  end

  assign sda       = line_now[1];
  assign scl_rise  =  line_now[0] & ~line_prev[0];
  assign scl_fall  = ~line_now[0] &  line_prev[0];
  // SDA may only move while SCL is steadily high for a START/STOP.
  assign start_det =  line_now[0] & line_prev[0] &  line_prev[1] & ~line_now[1];
  assign stop_det  =  line_now[0] & line_prev[0] & ~line_prev[1] &  line_now[1];

endmodule

// File: rtl/i2c_eeprom.sv
// 24Cxx-style byte-addressed EEPROM emulated as an I2C slave.
// Storage is a flop array so that reset can restore every byte to 8'hFF.
module i2c_eeprom
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] ADDRESS    = DEF_ADDRESS,
  parameter int         MEM_BYTES  = DEF_MEM_BYTES,
  parameter int         PAGE_BYTES = DEF_PAGE_BYTES
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  i2c_eeprom_if.slave  bus
);

  localparam int ADDR_W = $clog2(MEM_BYTES);
  localparam int PAGE_W = $clog2(PAGE_BYTES);

  logic scl_rise, scl_fall, start_det, stop_det, sda;

  i2c_line_sync u_sync (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda)
  );

  state_t              state_reg;
  logic [3:0]          bit_cnt_reg;
  logic [6:0]          shift_reg;
  logic                rw_reg;
  logic [ADDR_W-1:0]   ptr_reg;
  logic                sda_oe_reg;
  logic                busy_reg;
  logic [7:0]          mem_reg [MEM_BYTES];

  logic [7:0]          byte_in;
  logic [7:0]          rd_byte;
  logic [ADDR_W-1:0]   ptr_page_next;
  logic                wr_en;

  assign byte_in = {shift_reg, sda};
  assign rd_byte = mem_reg[ptr_reg];
  // A byte commits on the rising edge of its 8th bit.
  assign wr_en   = (state_reg == WRITE) && scl_rise && (bit_cnt_reg == 4'd7);

  assign bus.sda_oe_o = sda_oe_reg;
  assign bus.busy_o   = busy_reg;

  // Write pointer advance: low page bits wrap, page number is held.
  always_comb begin
    ptr_page_next = ptr_reg;
    ptr_page_next[PAGE_W-1:0] = ptr_reg[PAGE_W-1:0] + PAGE_W'(1);
  end

  // Storage array: cleared to 8'hFF on reset, one byte written per data byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_reg[i] <= 8'hFF;
    end else if (wr_en) begin
      mem_reg[ptr_reg] <= byte_in;
    end
  end

  // Protocol FSM; SDA drive is only updated on detected SCL falling edges,
  // except START/STOP which always release it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      rw_reg      <= WRITE_BIT;
      ptr_reg     <= '0;
      sda_oe_reg  <= 1'b0;
      busy_reg    <= 1'b0;
    end else if (start_det) begin
      state_reg   <= DEV_ADDR;
      bit_cnt_reg <= '0;
      sda_oe_reg  <= 1'b0;
      busy_reg    <= 1'b1;
    end else if (stop_det) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      sda_oe_reg  <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        DEV_ADDR, WORD_ADDR, WRITE: begin
          if (scl_rise) begin
            shift_reg <= byte_in[6:0];
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_reg <= '0;
              if (state_reg == DEV_ADDR) begin
                rw_reg    <= byte_in[0];
                state_reg <= (byte_in[7:1] == ADDRESS) ? ACK_DEV : IGNORE;
              end else if (state_reg == WORD_ADDR) begin
                ptr_reg   <= byte_in[ADDR_W-1:0];
                state_reg <= ACK_WORD;
              end else begin
                ptr_reg   <= ptr_page_next;
                state_reg <= ACK_WRITE;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
        end
        // First fall after the byte pulls SDA low; the fall after the
        // 9th clock ends the ack (sda_oe_reg tells the two apart).
        ACK_DEV, ACK_WORD, ACK_WRITE: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_reg <= 1'b1;
            end else if (state_reg == ACK_DEV && rw_reg == READ_BIT) begin
              state_reg   <= READ;
              bit_cnt_reg <= '0;
              sda_oe_reg  <= ~rd_byte[7];
            end else begin
              state_reg  <= (state_reg == ACK_DEV) ? WORD_ADDR : WRITE;
              sda_oe_reg <= 1'b0;
            end
          end
        end
        READ: begin
          if (scl_rise) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_reg  <= 1'b0;
              ptr_reg     <= ptr_reg + ADDR_W'(1);
              bit_cnt_reg <= '0;
              state_reg   <= MACK;
            end else begin
              sda_oe_reg <= ~rd_byte[~bit_cnt_reg[2:0]];
            end
          end
        end
        // bit_cnt_reg==1 marks a master ACK seen on this 9th clock.
        MACK: begin
          if (scl_rise) begin
            if (sda) state_reg <= IGNORE;
            else     bit_cnt_reg <= 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            state_reg   <= READ;
            bit_cnt_reg <= '0;
            sda_oe_reg  <= ~rd_byte[7];
          end
        end
        IDLE, IGNORE: begin
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_eeprom.sv
// Bench for i2c_eeprom: bit-banged I2C master, open-drain SDA resolution,
// a reference memory image and a scoreboard of expected read bytes.
module tb_i2c_eeprom;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_eeprom_if bus ();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe_o;

  i2c_eeprom dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] model_mem [256];
  logic [7:0] wr_q [$];

  typedef struct { string tag; logic [7:0] exp; } sb_t;
  sb_t sb_q [$];

  typedef struct { logic [7:0] waddr; logic [7:0] wdata; logic [7:0] exp_rd; } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(8);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(4);
    b = bus.sda_i;
    wait_clk(4);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(6);
    sda_m = 1'b0;
    wait_clk(6);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(6);
    sda_m = 1'b1;
    wait_clk(6);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      b[i] = bt;
    end
  endtask

  task automatic send_acked(input logic [7:0] b, input string name);
    logic ack;
    send_byte(b, ack);
    check(name, {31'd0, ack}, 32'd0);
  endtask

  // Queue the reference image contents for n sequential reads.
  task automatic expect_model(input logic [7:0] addr, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = addr + 8'(i);
      sb_q.push_back('{tag, model_mem[a]});
    end
  endtask

  // Read n bytes (ACK all but the last), checking each against the scoreboard.
  task automatic read_bytes(input int n);
    logic [7:0] b;
    sb_t e;
    for (int i = 0; i < n; i++) begin
      recv_byte(b);
      write_bit(i == n - 1);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: got 0x%02h with no expected entry", b);
      end else begin
        e = sb_q.pop_front();
        check(e.tag, {24'd0, b}, {24'd0, e.exp});
        $display("[TB] read %s byte %0d data=0x%02h", e.tag, i, b);
      end
    end
  endtask

  task automatic write_tx(input logic [7:0] waddr, input string tag);
    logic [7:0] loc;
    i2c_start();
    send_acked(8'hA0, {tag, " dev ack"});
    send_acked(waddr, {tag, " word ack"});
    for (int i = 0; i < wr_q.size(); i++) begin
      send_acked(wr_q[i], {tag, " data ack"});
      loc = {waddr[7:4], 4'(waddr[3:0] + 4'(i))};
      model_mem[loc] = wr_q[i];
    end
    i2c_stop();
    $display("[TB] write %s addr=0x%02h bytes=%0d", tag, waddr, wr_q.size());
    wr_q.delete();
  endtask

  task automatic rand_read(input logic [7:0] waddr, input int n, input string tag);
    i2c_start();
    send_acked(8'hA0, {tag, " dev ack"});
    send_acked(waddr, {tag, " word ack"});
    i2c_start();
    send_acked(8'hA1, {tag, " rdev ack"});
    read_bytes(n);
    i2c_stop();
  endtask

  task automatic cur_read(input int n, input string tag);
    i2c_start();
    send_acked(8'hA1, {tag, " rdev ack"});
    read_bytes(n);
    i2c_stop();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, want finish within time limit");
    $fatal(1);
  end

  initial begin
    logic ack;

    for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
    vecs[0] = '{8'h10, 8'h5A, 8'h5A};
    vecs[1] = '{8'h80, 8'hC3, 8'hC3};
    vecs[2] = '{8'hFF, 8'h00, 8'h00};
    vecs[3] = '{8'h3C, 8'hA5, 8'hA5};
    vecs[4] = '{8'h02, 8'h77, 8'h77};

    // Reset state
    wait_clk(5);
    check("reset sda_oe", {31'd0, bus.sda_oe_o}, 32'd0);
    check("reset busy", {31'd0, bus.busy_o}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Address mismatch: 0xA2 must be NACKed and leave SDA alone
    i2c_start();
    check("busy after start", {31'd0, bus.busy_o}, 32'd1);
    send_byte(8'hA2, ack);
    check("mismatch nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("mismatch busy", {31'd0, bus.busy_o}, 32'd0);
    check("mismatch sda_oe", {31'd0, bus.sda_oe_o}, 32'd0);
    $display("[TB] mismatch addr 0xA2 ack=%0b", ack);

    // Page wrap: 0x0E..0x01 within page 0, 0x10 untouched
    wr_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_tx(8'h0E, "page");
    sb_q.push_back('{"page 0E", 8'h11});
    sb_q.push_back('{"page 0F", 8'h22});
    sb_q.push_back('{"page 10", 8'hFF});
    rand_read(8'h0E, 3, "page");
    sb_q.push_back('{"page 00", 8'h33});
    sb_q.push_back('{"page 01", 8'h44});
    rand_read(8'h00, 2, "page");

    // Table: single byte write then random read with NACK
    for (int v = 0; v < 5; v++) begin
      wr_q.push_back(vecs[v].wdata);
      write_tx(vecs[v].waddr, "vec");
      sb_q.push_back('{$sformatf("vec%0d rd", v), vecs[v].exp_rd});
      rand_read(vecs[v].waddr, 1, "vec");
    end

    // Sequential read wrap from 0xFF, then current-address read
    i2c_start();
    send_acked(8'hA0, "setptr dev ack");
    send_acked(8'hFF, "setptr word ack");
    i2c_stop();
    expect_model(8'hFF, 3, "seqwrap");
    cur_read(3, "seqwrap");
    expect_model(8'h02, 1, "curaddr");
    cur_read(1, "curaddr");

    // Abort: STOP after 4 data bits must not write 0x20
    i2c_start();
    send_acked(8'hA0, "abort dev ack");
    send_acked(8'h20, "abort word ack");
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    i2c_stop();
    check("abort sda_oe", {31'd0, bus.sda_oe_o}, 32'd0);
    check("abort busy", {31'd0, bus.busy_o}, 32'd0);
    expect_model(8'h20, 1, "abort");
    rand_read(8'h20, 1, "abort");

    // Reset while the slave drives bit 7 (=0) of 0x5A at 0x10
    i2c_start();
    send_acked(8'hA0, "rst dev ack");
    send_acked(8'h10, "rst word ack");
    i2c_start();
    send_acked(8'hA1, "rst rdev ack");
    wait_clk(6);
    check("pre-reset driving", {31'd0, bus.sda_oe_o}, 32'd1);
    rst_n = 1'b0;
    wait_clk(2);
    check("in-reset sda_oe", {31'd0, bus.sda_oe_o}, 32'd0);
    check("in-reset busy", {31'd0, bus.busy_o}, 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    $display("[TB] reset during read applied");
    for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
    expect_model(8'h00, 256, "postreset");
    rand_read(8'h00, 256, "postreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
